// File: rtl/ex_stage_pkg.sv
// Shared types and constants for the execute stage and its iterative divider.
package ex_stage_pkg;

  localparam int XLEN = 32;

  typedef enum logic [4:0] {
    ALU_NONE, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU,
    ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
    ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU,
    ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU,
    ALU_JAL, ALU_JALR
  } ex_func;

  typedef enum logic { RS1_VALUE, RS1_PC } rs1_sel;
  typedef enum logic { RS2_VALUE, RS2_IMM } rs2_sel;
  typedef enum logic { WB_SRC_ALU, WB_SRC_MEM } wb_source_type;
  typedef enum logic { WB_PC_RESULT, WB_PC_NEXT } wb_pc_source_type;

  typedef enum logic [1:0] { DIV_IDLE, DIV_BUSY, DIV_DONE } div_state_t;

  localparam logic [XLEN-1:0] ZERO    = '0;
  localparam logic            DISABLE = 1'b0;

  function automatic logic is_div_func(input ex_func f);
    return f inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  endfunction

endpackage

// File: rtl/ex_stage_div_unit.sv
// Iterative radix-2 restoring divider: one quotient bit per cycle, with the
// divide-by-zero and signed-overflow cases resolved without iterating.
module div_unit
  import ex_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            n_rst,
  input  logic            start,
  input  logic            signed_op,
  input  logic            rem_op,
  input  logic            flush,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int              CW         = $clog2(XLEN + 1);
  localparam logic [CW-1:0]   COUNT_INIT = CW'(XLEN);
  localparam logic [CW-1:0]   COUNT_LAST = CW'(1);
  localparam logic [XLEN-1:0] MIN_INT    = {1'b1, {(XLEN-1){1'b0}}};

  div_state_t      state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] quot_q, quot_d, rem_q, rem_d, dsor_q, dsor_d;
  logic            neg_quot_q, neg_quot_d, neg_rem_q, neg_rem_d, rem_op_q, rem_op_d;

  logic            dividend_neg, divisor_neg, launch;
  logic [XLEN-1:0] dividend_mag, divisor_mag;
  logic [XLEN:0]   shifted, trial;

  assign dividend_neg = signed_op & dividend[XLEN-1];
  assign divisor_neg  = signed_op & divisor[XLEN-1];
  assign dividend_mag = dividend_neg ? -dividend : dividend;
  assign divisor_mag  = divisor_neg ? -divisor : divisor;
  // A new divide is never launched while reset is held, so stall stays low.
  assign launch       = start && !flush && n_rst;
  assign shifted      = {rem_q, quot_q[XLEN-1]};
  assign trial        = shifted - {1'b0, dsor_q};

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    dsor_d     = dsor_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    rem_op_d   = rem_op_q;
    case (state_q)
      DIV_IDLE: begin
        if (launch) begin
          rem_op_d = rem_op;
          if (divisor == '0) begin
            quot_d     = '1;
            rem_d      = dividend;
            neg_quot_d = 1'b0;
            neg_rem_d  = 1'b0;
            state_d    = DIV_DONE;
          end else if (signed_op && dividend == MIN_INT && divisor == '1) begin
            quot_d     = MIN_INT;
            rem_d      = '0;
            neg_quot_d = 1'b0;
            neg_rem_d  = 1'b0;
            state_d    = DIV_DONE;
          end else begin
            quot_d     = dividend_mag;
            rem_d      = '0;
            dsor_d     = divisor_mag;
            neg_quot_d = dividend_neg ^ divisor_neg;
            neg_rem_d  = dividend_neg;
            count_d    = COUNT_INIT;
            state_d    = DIV_BUSY;
          end
        end
      end
      DIV_BUSY: begin
        // Restoring step: keep the trial difference only if it did not borrow.
        if (trial[XLEN]) begin
          rem_d  = shifted[XLEN-1:0];
          quot_d = {quot_q[XLEN-2:0], 1'b0};
        end else begin
          rem_d  = trial[XLEN-1:0];
          quot_d = {quot_q[XLEN-2:0], 1'b1};
        end
        count_d = count_q - COUNT_LAST;
        if (count_q == COUNT_LAST) state_d = DIV_DONE;
      end
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
    if (flush) state_d = DIV_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values computed above.
  always_ff @(posedge clk_i or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= DIV_IDLE;
      count_q    <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      dsor_q     <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      rem_op_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      dsor_q     <= dsor_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      rem_op_q   <= rem_op_d;
    end
  end

  assign busy   = !flush && ((state_q == DIV_IDLE && launch) || state_q == DIV_BUSY);
  assign done   = !flush && state_q == DIV_DONE;
  assign result = rem_op_q ? (neg_rem_q ? -rem_q : rem_q)
                           : (neg_quot_q ? -quot_q : quot_q);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand select, single-cycle ALU/MUL, branch resolution and
// an iterative divider that stalls the front end while it runs.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic             clk_i,
  input  logic             n_rst,
  input  logic             flush_i,
  input  logic [XLEN-1:0]  pc_i,
  input  ex_func           func_i,
  input  rs1_sel           rs1_sel_i,
  input  rs2_sel           rs2_sel_i,
  input  logic [XLEN-1:0]  rs1_data_i,
  input  logic [XLEN-1:0]  rs2_data_i,
  input  logic [XLEN-1:0]  immediate_i,
  input  logic             memwrite_en_i,
  input  logic             memread_en_i,
  input  logic             wb_en_i,
  input  wb_source_type    wb_src_i,
  input  wb_pc_source_type wb_pc_src_i,
  output logic [XLEN-1:0]  result_o,
  output logic [XLEN-1:0]  store_data_o,
  output logic             branch_taken_o,
  output logic [XLEN-1:0]  branch_target_o,
  output logic             stall_o,
  output logic             memwrite_en_o,
  output logic             memread_en_o,
  output logic             wb_en_o,
  output wb_source_type    wb_src_o,
  output wb_pc_source_type wb_pc_src_o
);

  logic [XLEN-1:0]   opa, opb, div_result, jalr_sum;
  logic [4:0]        shamt;
  logic [2*XLEN-1:0] mul_a, mul_b, product;
  logic              div_done, branch_cond;

  assign opa   = (rs1_sel_i == RS1_PC) ? pc_i : rs1_data_i;
  assign opb   = (rs2_sel_i == RS2_IMM) ? immediate_i : rs2_data_i;
  assign shamt = opb[4:0];

  // One shared multiplier; the operand extension picks the signedness.
  assign mul_a   = (func_i == ALU_MULH || func_i == ALU_MULHSU)
                   ? {{XLEN{opa[XLEN-1]}}, opa} : {{XLEN{1'b0}}, opa};
  assign mul_b   = (func_i == ALU_MULH) ? {{XLEN{opb[XLEN-1]}}, opb} : {{XLEN{1'b0}}, opb};
  assign product = mul_a * mul_b;

  div_unit #(.XLEN(XLEN)) u_div (
    .clk_i     (clk_i),
    .n_rst     (n_rst),
    .start     (is_div_func(func_i)),
    .signed_op (func_i == ALU_DIV || func_i == ALU_REM),
    .rem_op    (func_i == ALU_REM || func_i == ALU_REMU),
    .flush     (flush_i),
    .dividend  (opa),
    .divisor   (opb),
    .busy      (stall_o),
    .done      (div_done),
    .result    (div_result)
  );

  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    result_o = '0;
    case (func_i)
      ALU_ADD:    result_o = opa + opb;
      ALU_SUB:    result_o = opa - opb;
      ALU_AND:    result_o = opa & opb;
      ALU_OR:     result_o = opa | opb;
      ALU_XOR:    result_o = opa ^ opb;
      ALU_SLL:    result_o = opa << shamt;
      ALU_SRL:    result_o = opa >> shamt;
      ALU_SRA:    result_o = $signed(opa) >>> shamt;
      ALU_SLT:    result_o = {{(XLEN-1){1'b0}}, $signed(opa) < $signed(opb)};
      ALU_SLTU:   result_o = {{(XLEN-1){1'b0}}, opa < opb};
      ALU_MUL:    result_o = product[XLEN-1:0];
      ALU_MULH, ALU_MULHSU, ALU_MULHU: result_o = product[2*XLEN-1:XLEN];
      ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU: result_o = div_done ? div_result : '0;
      ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU, ALU_JAL, ALU_JALR:
                  result_o = opa + opb;
      default:    result_o = '0;
    endcase
  end

  always_comb begin
    branch_cond = DISABLE;
    case (func_i)
      ALU_BEQ:  branch_cond = rs1_data_i == rs2_data_i;
      ALU_BNE:  branch_cond = rs1_data_i != rs2_data_i;
      ALU_BLT:  branch_cond = $signed(rs1_data_i) < $signed(rs2_data_i);
      ALU_BGE:  branch_cond = $signed(rs1_data_i) >= $signed(rs2_data_i);
      ALU_BLTU: branch_cond = rs1_data_i < rs2_data_i;
      ALU_BGEU: branch_cond = rs1_data_i >= rs2_data_i;
      ALU_JAL, ALU_JALR: branch_cond = 1'b1;
      default:  branch_cond = DISABLE;
    endcase
  end

  assign jalr_sum        = rs1_data_i + immediate_i;
  assign branch_target_o = (func_i == ALU_JALR) ? {jalr_sum[XLEN-1:1], 1'b0} : pc_i + immediate_i;
  assign branch_taken_o  = branch_cond && !stall_o;
  assign store_data_o    = rs2_data_i;

  assign memwrite_en_o = memwrite_en_i;
  assign memread_en_o  = memread_en_i;
  assign wb_en_o       = wb_en_i;
  assign wb_src_o      = wb_src_i;
  assign wb_pc_src_o   = wb_pc_src_i;

endmodule

// File: tb/tb_ex_stage.sv
// Directed-vector bench for ex_stage: ALU/MUL/branch vectors, divider latency,
// special divide cases, flush and reset during a divide.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic             clk_i = 1'b0;
  logic             n_rst = 1'b0;
  logic             flush_i = 1'b0;
  logic [31:0]      pc_i = '0, rs1_data_i = '0, rs2_data_i = '0, immediate_i = '0;
  ex_func           func_i = ALU_NONE;
  rs1_sel           rs1_sel_i = RS1_VALUE;
  rs2_sel           rs2_sel_i = RS2_VALUE;
  logic             memwrite_en_i = 1'b0, memread_en_i = 1'b0, wb_en_i = 1'b0;
  wb_source_type    wb_src_i = WB_SRC_ALU;
  wb_pc_source_type wb_pc_src_i = WB_PC_RESULT;

  logic [31:0]      result_o, store_data_o, branch_target_o;
  logic             branch_taken_o, stall_o, memwrite_en_o, memread_en_o, wb_en_o;
  wb_source_type    wb_src_o;
  wb_pc_source_type wb_pc_src_o;

  int n_checks = 0;
  int n_bad    = 0;

  ex_stage #(.XLEN(32)) dut (
    .clk_i(clk_i), .n_rst(n_rst), .flush_i(flush_i), .pc_i(pc_i), .func_i(func_i),
    .rs1_sel_i(rs1_sel_i), .rs2_sel_i(rs2_sel_i), .rs1_data_i(rs1_data_i),
    .rs2_data_i(rs2_data_i), .immediate_i(immediate_i),
    .memwrite_en_i(memwrite_en_i), .memread_en_i(memread_en_i), .wb_en_i(wb_en_i),
    .wb_src_i(wb_src_i), .wb_pc_src_i(wb_pc_src_i),
    .result_o(result_o), .store_data_o(store_data_o), .branch_taken_o(branch_taken_o),
    .branch_target_o(branch_target_o), .stall_o(stall_o),
    .memwrite_en_o(memwrite_en_o), .memread_en_o(memread_en_o), .wb_en_o(wb_en_o),
    .wb_src_o(wb_src_o), .wb_pc_src_o(wb_pc_src_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One combinational vector, applied at the falling edge and sampled 1 ns later.
  task automatic alu_vec(input string tag, input ex_func f, input rs1_sel s1, input rs2_sel s2,
                         input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic [31:0] exp_res,
                         input logic exp_taken, input logic [31:0] exp_target);
    @(negedge clk_i);
    func_i = f; rs1_sel_i = s1; rs2_sel_i = s2;
    pc_i = pc; rs1_data_i = a; rs2_data_i = b; immediate_i = imm;
    #1;
    check({tag, "_result"}, result_o, exp_res);
    check({tag, "_taken"}, {31'd0, branch_taken_o}, {31'd0, exp_taken});
    check({tag, "_stall"}, {31'd0, stall_o}, 32'd0);
    if (exp_taken) check({tag, "_target"}, branch_target_o, exp_target);
  endtask

  // Apply a divide, count stall cycles (bounded), then check the DONE-cycle result.
  task automatic run_div(input string tag, input ex_func f, input logic [31:0] a,
                         input logic [31:0] b, input int exp_cycles, input logic [31:0] exp_res);
    int cycles;
    @(negedge clk_i);
    func_i = f; rs1_sel_i = RS1_VALUE; rs2_sel_i = RS2_VALUE;
    rs1_data_i = a; rs2_data_i = b;
    #1;
    cycles = 0;
    while (stall_o && cycles < 200) begin
      cycles++;
      @(negedge clk_i);
      #1;
    end
    check({tag, "_cycles"}, cycles, exp_cycles);
    check({tag, "_result"}, result_o, exp_res);
  endtask

  task automatic go_idle();
    @(negedge clk_i);
    func_i = ALU_NONE;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    memwrite_en_i = 1'b1; wb_src_i = WB_SRC_MEM; wb_pc_src_i = WB_PC_NEXT; rs2_data_i = 32'h1234_5678;
    #1;
    check("reset_stall", {31'd0, stall_o}, 32'd0);
    check("reset_result_none", result_o, 32'd0);
    check("reset_taken_none", {31'd0, branch_taken_o}, 32'd0);
    check("pass_memwrite", {31'd0, memwrite_en_o}, 32'd1);
    check("pass_wb_src", {31'd0, wb_src_o == WB_SRC_MEM}, 32'd1);
    check("pass_wb_pc_src", {31'd0, wb_pc_src_o == WB_PC_NEXT}, 32'd1);
    check("store_data", store_data_o, 32'h1234_5678);
    @(negedge clk_i);
    n_rst = 1'b1;

    // tag, func, rs1_sel, rs2_sel, pc, rs1, rs2, imm, result, taken, target
    alu_vec("add_imm_wrap", ALU_ADD,   RS1_VALUE, RS2_IMM,   32'h0,   32'hFFFF_FFFF, 32'h0, 32'h1, 32'h0, 1'b0, 32'h0);
    alu_vec("add_pc",       ALU_ADD,   RS1_PC,    RS2_IMM,   32'h100, 32'h0, 32'h0, 32'h4, 32'h104, 1'b0, 32'h0);
    alu_vec("sub_wrap",     ALU_SUB,   RS1_VALUE, RS2_VALUE, 32'h0,   32'h0, 32'h1, 32'h0, 32'hFFFF_FFFF, 1'b0, 32'h0);
    alu_vec("sra_shamt",    ALU_SRA,   RS1_VALUE, RS2_VALUE, 32'h0,   32'h8000_0000, 32'h24, 32'h0, 32'hF800_0000, 1'b0, 32'h0);
    alu_vec("srl",          ALU_SRL,   RS1_VALUE, RS2_VALUE, 32'h0,   32'h8000_0000, 32'h4, 32'h0, 32'h0800_0000, 1'b0, 32'h0);
    alu_vec("slt",          ALU_SLT,   RS1_VALUE, RS2_VALUE, 32'h0,   32'hFFFF_FFFF, 32'h1, 32'h0, 32'h1, 1'b0, 32'h0);
    alu_vec("sltu",         ALU_SLTU,  RS1_VALUE, RS2_VALUE, 32'h0,   32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 1'b0, 32'h0);
    alu_vec("mul_low",      ALU_MUL,   RS1_VALUE, RS2_VALUE, 32'h0,   32'h7, 32'hFFFF_FFFD, 32'h0, 32'hFFFF_FFEB, 1'b0, 32'h0);
    alu_vec("mulh",         ALU_MULH,  RS1_VALUE, RS2_VALUE, 32'h0,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0, 32'h0);
    alu_vec("mulhsu",       ALU_MULHSU,RS1_VALUE, RS2_VALUE, 32'h0,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 1'b0, 32'h0);
    alu_vec("mulhu",        ALU_MULHU, RS1_VALUE, RS2_VALUE, 32'h0,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFE, 1'b0, 32'h0);
    alu_vec("blt_taken",    ALU_BLT,   RS1_VALUE, RS2_VALUE, 32'h100, 32'hFFFF_FFFF, 32'h0, 32'h20, 32'hFFFF_FFFF, 1'b1, 32'h120);
    alu_vec("bge_not",      ALU_BGE,   RS1_VALUE, RS2_VALUE, 32'h100, 32'hFFFF_FFFF, 32'h0, 32'h20, 32'hFFFF_FFFF, 1'b0, 32'h0);
    alu_vec("bltu_not",     ALU_BLTU,  RS1_VALUE, RS2_VALUE, 32'h100, 32'hFFFF_FFFF, 32'h0, 32'h20, 32'hFFFF_FFFF, 1'b0, 32'h0);
    alu_vec("jalr",         ALU_JALR,  RS1_VALUE, RS2_IMM,   32'h100, 32'h203, 32'h0, 32'h11, 32'h214, 1'b1, 32'h214);
    alu_vec("none",         ALU_NONE,  RS1_VALUE, RS2_VALUE, 32'h100, 32'h5, 32'h5, 32'h0, 32'h0, 1'b0, 32'h0);

    // Divides; DIV and REM run back to back with no bubble in between.
    run_div("div_m7_2",    ALU_DIV,  32'hFFFF_FFF9, 32'h2, 33, 32'hFFFF_FFFD);
    run_div("rem_m7_2",    ALU_REM,  32'hFFFF_FFF9, 32'h2, 33, 32'hFFFF_FFFF);
    run_div("div_7_m2",    ALU_DIV,  32'h7, 32'hFFFF_FFFE, 33, 32'hFFFF_FFFD);
    run_div("rem_7_m2",    ALU_REM,  32'h7, 32'hFFFF_FFFE, 33, 32'h1);
    run_div("divu_5_0",    ALU_DIVU, 32'h5, 32'h0, 1, 32'hFFFF_FFFF);
    run_div("remu_5_0",    ALU_REMU, 32'h5, 32'h0, 1, 32'h5);
    run_div("rem_m5_0",    ALU_REM,  32'hFFFF_FFFB, 32'h0, 1, 32'hFFFF_FFFB);
    run_div("div_ovf",     ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000);
    run_div("rem_ovf",     ALU_REM,  32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0);
    run_div("divu_big",    ALU_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0);
    go_idle();

    // Flush in the 10th BUSY cycle aborts the divide.
    @(negedge clk_i);
    func_i = ALU_DIVU; rs1_data_i = 32'd100; rs2_data_i = 32'd7;
    repeat (10) @(negedge clk_i);
    flush_i = 1'b1;
    #1;
    check("flush_stall", {31'd0, stall_o}, 32'd0);
    @(negedge clk_i);
    flush_i = 1'b0; func_i = ALU_NONE;
    #1;
    check("flush_idle_stall", {31'd0, stall_o}, 32'd0);
    check("flush_idle_result", result_o, 32'd0);
    run_div("divu_100_7", ALU_DIVU, 32'd100, 32'd7, 33, 32'd14);
    run_div("remu_100_7", ALU_REMU, 32'd100, 32'd7, 33, 32'd2);
    go_idle();

    // Reset in the middle of a divide, with the divide still presented.
    @(negedge clk_i);
    func_i = ALU_DIVU; rs1_data_i = 32'd100; rs2_data_i = 32'd7;
    repeat (5) @(negedge clk_i);
    n_rst = 1'b0;
    #1;
    check("rst_mid_stall", {31'd0, stall_o}, 32'd0);
    @(negedge clk_i);
    func_i = ALU_NONE; n_rst = 1'b1;
    #1;
    check("rst_after_stall", {31'd0, stall_o}, 32'd0);
    run_div("div_after_rst", ALU_DIV, 32'hFFFF_FFF9, 32'h2, 33, 32'hFFFF_FFFD);
    go_idle();

    repeat (2) @(negedge clk_i);
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
